// File: rtl/controlpath_seq.sv
// Registered instruction decoder: turns one instruction word into a burst of
// ALU/datapath control beats with auto-striding register selects.
module controlpath_seq #(
    parameter int REG_BITS = 4,
    parameter int REP_BITS = 3,
    parameter int STRIDE   = 2,
    localparam int INSN_W  = 4*REG_BITS + 13 + REP_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INSN_W-1:0]   instruction,
    input  logic                insn_valid,
    output logic                insn_ready,
    input  logic                stall,
    output logic                ctl_valid,
    output logic                pc_inc,
    output logic [2:0]          alu_op,
    output logic                alu_form,
    output logic [1:0]          alu_vec_perci,
    output logic [3:0]          alu_config,
    output logic                const_c,
    output logic [REG_BITS-1:0] alu_a_select,
    output logic [REG_BITS-1:0] alu_b_select,
    output logic [REG_BITS-1:0] alu_c_select,
    output logic [REG_BITS-1:0] alu_d_select,
    output logic [REG_BITS-1:0] alu_Y1_select,
    output logic [REG_BITS-1:0] alu_Y2_select,
    output logic [1:0]          alu_write,
    output logic [REG_BITS-1:0] copy_select
);

    localparam int R = REG_BITS;
    localparam logic [REG_BITS-1:0] STEP = REG_BITS'(STRIDE);
    localparam logic [REG_BITS-1:0] ONE  = REG_BITS'(1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t              state_q;
    logic [REP_BITS-1:0] beat_cnt_q;
    logic                pc_inc_q;
    logic [2:0]          op_q;
    logic                form_q;
    logic [1:0]          vec_q;
    logic [3:0]          cfg_q;
    logic                cc_q;
    logic [1:0]          wr_q;
    logic [R-1:0]        a_q, b_q, c_q, d_q, y1_q, y2_q, copy_q;

    logic                accept;
    logic                last_beat;
    logic [R-1:0]        a_d, b_d, y1_d;

    // Fields of the incoming word
    assign a_d  = instruction[4*R-1:3*R];
    assign b_d  = instruction[3*R-1:2*R];
    assign y1_d = instruction[2*R-1:R];

    assign last_beat  = (beat_cnt_q == '0);
    assign insn_ready = !rst && ((state_q == IDLE) || (last_beat && !stall));
    assign accept     = insn_valid && insn_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            pc_inc_q   <= 1'b0;
            op_q       <= '0;
            form_q     <= 1'b0;
            vec_q      <= '0;
            cfg_q      <= '0;
            cc_q       <= 1'b0;
            wr_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            y1_q       <= '0;
            y2_q       <= '0;
            copy_q     <= '0;
        end else begin
            // pc_inc is a pure pulse: it never survives a stall
            pc_inc_q <= 1'b0;
            if (accept) begin
                state_q    <= BURST;
                beat_cnt_q <= instruction[INSN_W-1:4*R+13];
                pc_inc_q   <= 1'b1;
                op_q       <= instruction[4*R+12:4*R+10];
                form_q     <= instruction[4*R+9];
                vec_q      <= instruction[4*R+8:4*R+7];
                cfg_q      <= instruction[4*R+6:4*R+3];
                cc_q       <= instruction[4*R+2];
                wr_q       <= instruction[4*R+1:4*R];
                a_q        <= a_d;
                b_q        <= b_d;
                c_q        <= a_d + ONE;
                d_q        <= b_d + ONE;
                y1_q       <= y1_d;
                y2_q       <= y1_d + ONE;
                copy_q     <= instruction[R-1:0];
            end else if (state_q == BURST && !stall) begin
                if (!last_beat) begin
                    beat_cnt_q <= beat_cnt_q - REP_BITS'(1);
                    a_q        <= a_q + STEP;
                    b_q        <= b_q + STEP;
                    c_q        <= c_q + STEP;
                    d_q        <= d_q + STEP;
                    y1_q       <= y1_q + STEP;
                    y2_q       <= y2_q + STEP;
                end else begin
                    // Selects and fields persist; only the write enables drop
                    state_q <= IDLE;
                    wr_q    <= '0;
                end
            end
        end
    end

    assign ctl_valid     = (state_q == BURST);
    assign pc_inc        = pc_inc_q;
    assign alu_op        = op_q;
    assign alu_form      = form_q;
    assign alu_vec_perci = vec_q;
    assign alu_config    = cfg_q;
    assign const_c       = cc_q;
    assign alu_write     = wr_q;
    assign alu_a_select  = a_q;
    assign alu_b_select  = b_q;
    assign alu_c_select  = c_q;
    assign alu_d_select  = d_q;
    assign alu_Y1_select = y1_q;
    assign alu_Y2_select = y2_q;
    assign copy_select   = copy_q;

endmodule

// File: tb/tb_controlpath_seq.sv
// Scoreboard bench for controlpath_seq: expected beats are queued on accept
// and compared whenever the DUT presents a beat that is not stalled.
module tb_controlpath_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic        insn_valid;
    logic        insn_ready;
    logic        stall;
    logic        ctl_valid, pc_inc, alu_form, const_c;
    logic [2:0]  alu_op;
    logic [1:0]  alu_vec_perci, alu_write;
    logic [3:0]  alu_config;
    logic [3:0]  alu_a_select, alu_b_select, alu_c_select, alu_d_select;
    logic [3:0]  alu_Y1_select, alu_Y2_select, copy_select;

    controlpath_seq #(.REG_BITS(4), .REP_BITS(3), .STRIDE(2)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .insn_valid(insn_valid),
        .insn_ready(insn_ready), .stall(stall), .ctl_valid(ctl_valid), .pc_inc(pc_inc),
        .alu_op(alu_op), .alu_form(alu_form), .alu_vec_perci(alu_vec_perci),
        .alu_config(alu_config), .const_c(const_c),
        .alu_a_select(alu_a_select), .alu_b_select(alu_b_select),
        .alu_c_select(alu_c_select), .alu_d_select(alu_d_select),
        .alu_Y1_select(alu_Y1_select), .alu_Y2_select(alu_Y2_select),
        .alu_write(alu_write), .copy_select(copy_select)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] sel;
        logic [16:0] ctl;
    } beat_t;

    beat_t q[$];
    beat_t e;
    int    checks = 0;
    int    errors = 0;
    int    vcnt   = 0;
    int    pc_cnt = 0;
    bit    rnd_en = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] rep, input logic [2:0] op,
                                       input logic form, input logic [1:0] vec,
                                       input logic [3:0] cfg, input logic cc,
                                       input logic [1:0] wr, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] y1,
                                       input logic [3:0] cp);
        return {rep, op, form, vec, cfg, cc, wr, a, b, y1, cp};
    endfunction

    // Reference decode: one queue entry per beat of the burst
    task automatic push_beats(input logic [31:0] ins);
        logic [3:0] a, b, y1, k2;
        beat_t      bt;
        a  = ins[15:12];
        b  = ins[11:8];
        y1 = ins[7:4];
        for (int k = 0; k <= int'(ins[31:29]); k++) begin
            k2 = 4'(2 * k);
            bt.sel = {a + k2, b + k2, a + 4'd1 + k2, b + 4'd1 + k2, y1 + k2, y1 + 4'd1 + k2};
            bt.ctl = {ins[28:26], ins[25], ins[24:23], ins[22:19], ins[18], ins[17:16], ins[3:0]};
            q.push_back(bt);
        end
    endtask

    // Monitor: counts live cycles and compares each consumed beat
    always @(negedge clk) begin
        if (!rst) begin
            if (ctl_valid) vcnt++;
            if (pc_inc) pc_cnt++;
            if (ctl_valid && !stall) begin
                if (q.size() == 0) begin
                    chk("beat_unexpected", 64'(ctl_valid), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("beat_sel", 64'({alu_a_select, alu_b_select, alu_c_select,
                                         alu_d_select, alu_Y1_select, alu_Y2_select}), 64'(e.sel));
                    chk("beat_ctl", 64'({alu_op, alu_form, alu_vec_perci, alu_config,
                                         const_c, alu_write, copy_select}), 64'(e.ctl));
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_en) begin
            #1 stall = ($urandom_range(0, 2) == 0);
        end
    end

    // Returns 1ns after the accepting edge with insn_valid still high
    task automatic send(input logic [31:0] ins);
        logic ok;
        ok = 1'b0;
        instruction = ins;
        insn_valid  = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (insn_ready) begin
                @(posedge clk);
                push_beats(ins);
                ok = 1'b1;
                #1;
            end
        end
        if (!ok) chk("accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_idle();
        insn_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!ctl_valid) break;
        end
        chk("idle_timeout", 64'(ctl_valid), 64'd0);
        chk("write_idle", 64'(alu_write), 64'd0);
        chk("sb_empty", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return {ctl_valid, pc_inc, alu_op, alu_form, alu_vec_perci, alu_config, const_c,
                alu_a_select, alu_b_select, alu_c_select, alu_d_select,
                alu_Y1_select, alu_Y2_select, alu_write, copy_select};
    endfunction

    initial begin
        rst = 1'b1;
        instruction = '0;
        insn_valid = 1'b0;
        stall = 1'b0;
        #2;
        chk("rst_outs", all_outs(), 64'd0);
        chk("rst_ready", 64'(insn_ready), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rel_ready", 64'(insn_ready), 64'd1);
        chk("rel_valid", 64'(ctl_valid), 64'd0);

        // Single burst of three beats
        vcnt = 0; pc_cnt = 0;
        send(32'h56D7_4683);
        insn_valid = 1'b0;
        chk("b0_pc", 64'(pc_inc), 64'd1);
        chk("b0_ctl", 64'({alu_op, alu_form, alu_vec_perci, alu_config, const_c, alu_write, copy_select}),
            64'({3'd5, 1'b1, 2'd1, 4'hA, 1'b1, 2'd3, 4'd3}));
        chk("b0_sel", 64'({alu_a_select, alu_b_select, alu_c_select, alu_d_select,
                           alu_Y1_select, alu_Y2_select}), 64'h465789);
        @(posedge clk); #1;
        chk("b1_pc", 64'(pc_inc), 64'd0);
        chk("b1_sel", 64'({alu_a_select, alu_b_select, alu_c_select, alu_d_select,
                           alu_Y1_select, alu_Y2_select}), 64'h68_79AB);
        wait_idle();
        chk("single_vcnt", 64'(vcnt), 64'd3);
        chk("single_pc", 64'(pc_cnt), 64'd1);

        // Stall on the first beat for two cycles
        vcnt = 0; pc_cnt = 0;
        send(32'h56D7_4683);
        insn_valid = 1'b0;
        stall = 1'b1;
        #1 chk("stall_ready0", 64'(insn_ready), 64'd0);
        @(posedge clk); #1;
        chk("stall_pc_drop", 64'(pc_inc), 64'd0);
        chk("stall_ready1", 64'(insn_ready), 64'd0);
        chk("stall_hold", 64'({alu_a_select, alu_Y2_select}), 64'h49);
        @(posedge clk); #1;
        chk("stall_hold2", 64'({alu_a_select, alu_Y2_select}), 64'h49);
        stall = 1'b0;
        wait_idle();
        chk("stall_vcnt", 64'(vcnt), 64'd5);
        chk("stall_pc", 64'(pc_cnt), 64'd1);

        // Select wrap-around
        send(mk(3'd1, 3'd2, 1'b0, 2'd2, 4'h5, 1'b0, 2'd1, 4'hF, 4'hE, 4'hF, 4'h5));
        insn_valid = 1'b0;
        chk("wrap_b0", 64'({alu_c_select, alu_Y2_select}), 64'h00);
        @(posedge clk); #1;
        chk("wrap_b1", 64'({alu_a_select, alu_b_select, alu_c_select, alu_d_select,
                            alu_Y1_select, alu_Y2_select}), 64'h102112);
        wait_idle();

        // Back-to-back single-beat instructions
        vcnt = 0; pc_cnt = 0;
        send(mk(3'd0, 3'd1, 1'b1, 2'd0, 4'h3, 1'b1, 2'd2, 4'h1, 4'h2, 4'h3, 4'h4));
        send(mk(3'd0, 3'd6, 1'b0, 2'd3, 4'hC, 1'b0, 2'd1, 4'h9, 4'h8, 4'h7, 4'h6));
        chk("b2b_pc2", 64'(pc_inc), 64'd1);
        wait_idle();
        chk("b2b_vcnt", 64'(vcnt), 64'd2);
        chk("b2b_pc", 64'(pc_cnt), 64'd2);

        // Reset in the middle of a rep=3 burst
        send(mk(3'd3, 3'd4, 1'b1, 2'd1, 4'h7, 1'b1, 2'd3, 4'h2, 4'h4, 4'h6, 4'h1));
        insn_valid = 1'b0;
        #3 rst = 1'b1;
        q.delete();
        #1;
        chk("mid_rst_outs", all_outs(), 64'd0);
        chk("mid_rst_ready", 64'(insn_ready), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        vcnt = 0; pc_cnt = 0;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_vcnt", 64'(vcnt), 64'd0);
        chk("post_rst_ready", 64'(insn_ready), 64'd1);
        send(32'h56D7_4683);
        wait_idle();
        chk("post_rst_pc", 64'(pc_cnt), 64'd1);

        // Random traffic with random stalls
        pc_cnt = 0;
        rnd_en = 1;
        for (int i = 0; i < 8; i++) begin
            send($urandom());
            if ($urandom_range(0, 1) == 0) begin
                insn_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        wait_idle();
        rnd_en = 0;
        @(posedge clk); #2;
        stall = 1'b0;
        chk("rnd_pc", 64'(pc_cnt), 64'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
